// File: rtl/mmio_uart.sv
// Generic FIFO: pointers carry an extra wrap bit so full/empty are exact at depth boundaries.
// Latency: head_dat is the combinational read of the oldest entry; a push is visible one cycle later.
// Backpressure: a push on full is taken only if a pop happens in the same cycle, otherwise dropped.
module mmio_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop_rdy && !empty;
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// Memory-mapped full-duplex 8N1 UART: TX/RX FIFOs, runtime divisor, sticky errors, level irq.
// Latency: rdata registers on the sel&rstrb edge; irq lags its sources by one cycle.
// Backpressure: writes to a full TX FIFO and RX bytes arriving on a full RX FIFO are dropped.
module mmio_uart #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int DIV_W       = 16,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  input  logic        rstrb,
  output logic [31:0] rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ_HZ / BAUD_RATE);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic             wr_en, rd_en;
  logic [1:0]       reg_idx;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       ctrl_q;
  logic             overrun, framing_err;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  assign wr_en     = sel & wstrb;
  assign rd_en     = sel & rstrb;
  assign reg_idx   = addr[3:2];
  assign unused_ok = ^{addr[1:0], wdata[31:DIV_W]};

  logic       tx_push, tx_pop, tx_full, tx_empty, tx_busy, tx_tick;
  logic [7:0] tx_head, tx_shift;
  logic [2:0] tx_bit;
  logic [DIV_W-1:0] tx_cnt;
  uart_st_t   tx_state, tx_next;

  assign tx_push = wr_en && (reg_idx == 2'd0);
  assign tx_tick = (tx_cnt == '0);
  assign tx_busy = !tx_empty || (tx_state != IDLE);

  mmio_uart_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push_vld(tx_push), .push_dat(wdata[7:0]),
    .pop_rdy(tx_pop), .head_dat(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) tx_state <= IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (!tx_empty) tx_next = START;
      START:   if (tx_tick) tx_next = DATA;
      DATA:    if (tx_tick && tx_bit == 3'd7) tx_next = STOP;
      STOP:    if (tx_tick) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  always_comb begin
    txd    = 1'b1;
    tx_pop = 1'b0;
    case (tx_state)
      IDLE:    tx_pop = 1'b1;
      START:   txd = 1'b0;
      DATA:    txd = tx_shift[0];
      default: txd = 1'b1;
    endcase
  end

  // Bit timer reloads from div_q at every bit boundary, so a DIV write lands on the next bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_state == IDLE) begin
      tx_cnt   <= div_q - DIV_ONE;
      tx_bit   <= '0;
      tx_shift <= tx_head;
    end else if (tx_tick) begin
      tx_cnt <= div_q - DIV_ONE;
      if (tx_state == DATA) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + 3'd1;
      end
    end else begin
      tx_cnt <= tx_cnt - DIV_ONE;
    end
  end

  logic       rxd_s1, rxd_s2, rxd_d, rx_fall, rx_tick;
  logic       rx_push, rx_pop, rx_full, rx_empty, ovr_set, frm_set;
  logic [7:0] rx_head, rx_shift;
  logic [2:0] rx_bit;
  logic [DIV_W-1:0] rx_cnt;
  uart_st_t   rx_state, rx_next;

  assign rx_fall = rxd_d & ~rxd_s2;
  assign rx_tick = (rx_cnt == '0);
  assign rx_pop  = rd_en && (reg_idx == 2'd0);
  assign ovr_set = rx_push && rx_full && !rx_pop;

  mmio_uart_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push_vld(rx_push), .push_dat(rx_shift),
    .pop_rdy(rx_pop), .head_dat(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
      rx_state <= IDLE;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
      rx_state <= rx_next;
    end
  end

  // Re-arming needs a falling edge, so after a framing error the line must go high first.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (rx_fall) rx_next = START;
      START:   if (rx_tick) rx_next = rxd_s2 ? IDLE : DATA;
      DATA:    if (rx_tick && rx_bit == 3'd7) rx_next = STOP;
      STOP:    if (rx_tick) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  always_comb begin
    rx_push = 1'b0;
    frm_set = 1'b0;
    if (rx_state == STOP && rx_tick) begin
      rx_push = rxd_s2;
      frm_set = !rxd_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_state == IDLE) begin
      rx_cnt <= (div_q >> 1) - DIV_ONE;
      rx_bit <= '0;
    end else if (rx_tick) begin
      rx_cnt <= div_q - DIV_ONE;
      if (rx_state == DATA) begin
        rx_shift <= {rxd_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end else begin
      rx_cnt <= rx_cnt - DIV_ONE;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      2'd0:    rd_mux = {24'b0, rx_empty ? 8'h00 : rx_head};
      2'd1:    rd_mux = {22'b0, tx_busy, 3'b0, framing_err, overrun,
                         rx_full, !rx_empty, tx_empty, tx_full};
      2'd2:    rd_mux = 32'(div_q);
      default: rd_mux = {30'b0, ctrl_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q       <= DIV_RST;
      ctrl_q      <= '0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      rdata       <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_en && reg_idx == 2'd2)
        div_q <= (wdata[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : wdata[DIV_W-1:0];
      if (wr_en && reg_idx == 2'd3)
        ctrl_q <= wdata[1:0];
      overrun     <= ovr_set | (overrun & ~(wr_en && reg_idx == 2'd1 && wdata[4]));
      framing_err <= frm_set | (framing_err & ~(wr_en && reg_idx == 2'd1 && wdata[5]));
      if (rd_en) rdata <= rd_mux;
      irq <= (ctrl_q[0] & !rx_empty) | (ctrl_q[1] & !tx_busy);
    end
  end
endmodule

// File: tb/tb_mmio_uart.sv
// Randomised self-checking bench for mmio_uart: bit-level txd timing, FIFO queue model,
// sticky flags, divisor clamp, irq and mid-frame reset.
module tb_mmio_uart;
  localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_DIV = 4'h8, A_CTRL = 4'hC;

  logic        clk = 1'b0, resetn = 1'b0, sel = 1'b0, wstrb = 1'b0, rstrb = 1'b0, rxd = 1'b1;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        txd, irq;
  int          n_checks = 0, n_pass = 0, cyc = 0;

  mmio_uart #(.CLK_FREQ_HZ(10000000), .BAUD_RATE(1000000), .DIV_W(16),
              .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rstrb(rstrb), .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; addr = a; wdata = d; wstrb = 1'b1;
    tick(1);
    sel = 1'b0; wstrb = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; rstrb = 1'b1;
    tick(1);
    sel = 1'b0; rstrb = 1'b0;
    d = rdata;
  endtask

  // Drives one 8N1 frame on rxd, each bit held div clocks.
  task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int div);
    rxd = 1'b0;
    tick(div);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(div);
    end
    rxd = stop_bit;
    tick(div);
    rxd = 1'b1;
  endtask

  // Reference receiver: finds a start bit then samples txd mid-bit.
  task automatic sniff(input int div, output logic [7:0] b, output int t0, output bit ok);
    int waited;
    waited = 0; ok = 1'b0; b = '0; t0 = 0;
    while (txd !== 1'b0 && waited < 40 * div) begin
      tick(1);
      waited++;
    end
    if (txd !== 1'b0) return;
    t0 = cyc;
    tick(div / 2);
    for (int i = 0; i < 8; i++) begin
      tick(div);
      b[i] = txd;
    end
    tick(div);
    ok = (txd === 1'b1);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    resetn = 1'b0;
    tick(3);
    n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    resetn = 1'b1;
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h2) $display("FAIL reset_status: got %h want 2", d); else n_pass++;
    bus_read(A_CTRL, d);
    n_checks++; if (d !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", d); else n_pass++;
    bus_read(A_DIV, d);
    n_checks++; if (d !== 32'd10) $display("FAIL reset_div: got %0d want 10", d); else n_pass++;
    addr = A_STAT; rstrb = 1'b1;
    tick(1);
    rstrb = 1'b0;
    n_checks++; if (rdata !== 32'd10) $display("FAIL unsel_read_hold: got %h want a", rdata); else n_pass++;
  endtask

  task automatic test_tx_frame(input logic [7:0] b, input int div);
    logic [31:0] d;
    logic exp;
    int err;
    bus_write(A_DIV, 32'(div));
    bus_write(A_DATA, {24'b0, b});
    bus_read(A_STAT, d);
    n_checks++; if (d[9] !== 1'b1) $display("FAIL tx_busy_during: got %b want 1", d[9]); else n_pass++;
    for (int bit_i = 0; bit_i < 10; bit_i++) begin
      if (bit_i == 0) exp = 1'b0;
      else if (bit_i == 9) exp = 1'b1;
      else exp = b[bit_i-1];
      err = 0;
      for (int c = 0; c < div; c++) begin
        if (txd !== exp) err++;
        tick(1);
      end
      n_checks++;
      if (err != 0) $display("FAIL tx_bit%0d byte %h div %0d: %0d cycles wrong, want level %b", bit_i, b, div, err, exp);
      else n_pass++;
    end
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h2) $display("FAIL tx_status_after: got %h want 2", d); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [6];
    logic [31:0] d;
    logic [7:0] b;
    int t0, tprev;
    bit ok;
    tprev = 0;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    bus_write(A_DIV, 32'd10);
    fork
      begin
        for (int i = 0; i < 6; i++) bus_write(A_DATA, {24'b0, bytes[i]});
        bus_read(A_STAT, d);
        n_checks++; if (d[1:0] !== 2'b01) $display("FAIL b2b_tx_full: got %b want 01", d[1:0]); else n_pass++;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          sniff(10, b, t0, ok);
          n_checks++;
          if (!ok || b !== bytes[k]) $display("FAIL b2b_frame%0d: got %h ok=%0d want %h", k, b, ok, bytes[k]);
          else n_pass++;
          if (k > 0) begin
            n_checks++;
            if (t0 - tprev != 101) $display("FAIL b2b_spacing%0d: got %0d want 101", k, t0 - tprev);
            else n_pass++;
          end
          tprev = t0;
        end
      end
    join
    sniff(10, b, t0, ok);
    n_checks++; if (ok) $display("FAIL b2b_dropped: got extra frame %h want none", b); else n_pass++;
  endtask

  task automatic test_rx_basic(input logic [7:0] b);
    logic [31:0] d;
    drive_rx(b, 1'b1, 10);
    tick(3);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h6) $display("FAIL rx_status_full: got %h want 6", d); else n_pass++;
    bus_read(A_DATA, d);
    n_checks++; if (d !== {24'b0, b}) $display("FAIL rx_data: got %h want %h", d, b); else n_pass++;
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h2) $display("FAIL rx_status_empty: got %h want 2", d); else n_pass++;
    bus_read(A_DATA, d);
    n_checks++; if (d !== 32'h0) $display("FAIL rx_empty_read: got %h want 0", d); else n_pass++;
  endtask

  task automatic test_rx_overrun;
    logic [7:0] model [$];
    logic [7:0] b;
    logic [31:0] d, exp_stat;
    bit exp_ovr;
    exp_ovr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      drive_rx(b, 1'b1, 10);
      if (model.size() < 4) model.push_back(b);
      else exp_ovr = 1'b1;
    end
    tick(3);
    exp_stat = 32'h2 | 32'h4 | 32'h8 | (exp_ovr ? 32'h10 : 32'h0);
    bus_read(A_STAT, d);
    n_checks++; if (d !== exp_stat) $display("FAIL ovr_status: got %h want %h", d, exp_stat); else n_pass++;
    while (model.size() > 0) begin
      b = model.pop_front();
      bus_read(A_DATA, d);
      n_checks++; if (d !== {24'b0, b}) $display("FAIL ovr_data: got %h want %h", d, b); else n_pass++;
    end
    bus_read(A_DATA, d);
    n_checks++; if (d !== 32'h0) $display("FAIL ovr_drained: got %h want 0", d); else n_pass++;
    bus_write(A_STAT, 32'h10);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h2) $display("FAIL ovr_w1c: got %h want 2", d); else n_pass++;
  endtask

  task automatic test_framing_glitch;
    logic [31:0] d;
    drive_rx(8'($urandom), 1'b0, 10);
    tick(5);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h22) $display("FAIL framing_status: got %h want 22", d); else n_pass++;
    bus_write(A_STAT, 32'h20);
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(30);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h2) $display("FAIL glitch_status: got %h want 2", d); else n_pass++;
  endtask

  task automatic test_div_irq;
    logic [31:0] d;
    logic [7:0] b;
    b = 8'($urandom);
    bus_write(A_DIV, 32'd1);
    bus_read(A_DIV, d);
    n_checks++; if (d !== 32'd2) $display("FAIL div_clamp: got %0d want 2", d); else n_pass++;
    bus_write(A_DIV, 32'd10);
    bus_write(A_CTRL, 32'd1);
    tick(2);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_rx_idle: got %b want 0", irq); else n_pass++;
    drive_rx(b, 1'b1, 10);
    tick(3);
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_rx_pending: got %b want 1", irq); else n_pass++;
    bus_read(A_DATA, d);
    n_checks++; if (d !== {24'b0, b}) $display("FAIL irq_rx_data: got %h want %h", d, b); else n_pass++;
    tick(1);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_rx_cleared: got %b want 0", irq); else n_pass++;
    bus_write(A_CTRL, 32'd2);
    tick(2);
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_tx_idle: got %b want 1", irq); else n_pass++;
    bus_write(A_CTRL, 32'd0);
    tick(2);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_disabled: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    int lows;
    bus_write(A_DIV, 32'd7);
    bus_write(A_DATA, 32'h00);
    tick(20);
    n_checks++; if (txd !== 1'b0) $display("FAIL midframe_pre: got %b want 0", txd); else n_pass++;
    resetn = 1'b0;
    tick(1);
    n_checks++; if (txd !== 1'b1) $display("FAIL midframe_reset_txd: got %b want 1", txd); else n_pass++;
    resetn = 1'b1;
    bus_read(A_DIV, d);
    n_checks++; if (d !== 32'd10) $display("FAIL midframe_div: got %0d want 10", d); else n_pass++;
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h2) $display("FAIL midframe_status: got %h want 2", d); else n_pass++;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd !== 1'b1) lows++;
      tick(1);
    end
    n_checks++; if (lows != 0) $display("FAIL midframe_idle: got %0d low cycles want 0", lows); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_frame(8'h55, 10);
    test_tx_frame(8'($urandom), int'($urandom_range(12, 3)));
    test_back_to_back();
    test_rx_basic(8'hA3);
    test_rx_basic(8'($urandom));
    test_rx_overrun();
    test_framing_glitch();
    test_div_irq();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
